// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC/IR holder with a req/ack instruction-memory fetch FSM.
// Optional feature macro MISALIGN_TRAP_EN: word-aligns PC loads and raises a sticky misalign flag.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PC_LD,
  input  logic [1:0]        SEL_PC,
  input  logic              IR_W,
  input  logic              MEM_RD,
  input  logic              SEL_DIR,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       reg_rs,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [5:0]        OPCODE,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fetch_busy_q, fetch_busy_d;
  logic              fetch_done_q, fetch_done_d;
  logic [ADDR_W-1:0] pc_src;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};

  // PC source select; the jump target keeps the PC's top nibble
  always_comb begin
    pc_src = pc_inc;
    case (SEL_PC)
      2'b00:   pc_src = pc_inc;
      2'b01:   pc_src = alu_result[ADDR_W-1:0];
      2'b10:   pc_src = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
      2'b11:   pc_src = reg_rs[ADDR_W-1:0];
      default: pc_src = pc_inc;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (PC_LD) begin
      pc_d       = {pc_src[ADDR_W-1:2], 2'b00};
      misalign_d = misalign_q | (pc_src[1:0] != 2'b00);
    end else begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  always_comb begin
    pc_d = pc_q;
    if (PC_LD) begin
      pc_d = pc_src;
    end else begin
      pc_d = pc_q;
    end
  end

  assign misalign = 1'b0;
`endif

  // Fetch FSM next state; the address is captured at the start edge and held until ack
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    ir_d         = ir_q;
    fetch_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (IR_W && MEM_RD && !SEL_DIR) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end else begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          ir_d         = mem_rdata;
          fetch_done_d = 1'b1;
        end else begin
          state_d   = REQ;
          mem_req_d = 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    fetch_busy_d = (state_d != IDLE);
  end

  // State, PC and IR registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      ir_q         <= 32'h0000_0000;
      pc_q         <= PC_RESET[ADDR_W-1:0];
      fetch_busy_q <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      fetch_busy_q <= fetch_busy_d;
      fetch_done_q <= fetch_done_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_inc;
  assign OPCODE     = ir_q[31:26];
  assign rs         = ir_q[25:21];
  assign rt         = ir_q[20:16];
  assign rd         = ir_q[15:11];
  assign imm        = ir_q[15:0];
  assign fetch_busy = fetch_busy_q;
  assign fetch_done = fetch_done_q;

endmodule
